// File: rtl/fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : fetch_pkg                                                         |
// | Brief   : Prefetch queue sizing and slot types for the fetch stage.         |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
package fetch_pkg;

   localparam int PREFETCH_DEPTH = 4;

   typedef struct packed {
      instructions_pkg::arch_reg pc;
      instructions_pkg::arch_reg instr;
      logic                      filled;
   } prefetch_entry_t;

   typedef logic [$clog2(PREFETCH_DEPTH):0] prefetch_ptr_t;

endpackage
`default_nettype wire

// File: rtl/instructions_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : instructions_pkg                                                  |
// | Brief   : Architectural register/word types shared across the core.         |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
package instructions_pkg;

   typedef logic [31:0] arch_reg;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_buffer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : fetch_prefetch_buffer_if                                        |
// | Brief     : Redirect, memory request/response and fetch-stage output bus.   |
// | Rev       : 1.0                                                             |
// +-----------------------------------------------------------------------------+
interface fetch_prefetch_buffer_if;

   logic                      redirect_valid;
   instructions_pkg::arch_reg redirect_pc;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   instructions_pkg::arch_reg mem_req_addr;
   logic                      mem_resp_valid;
   instructions_pkg::arch_reg mem_resp_data;
   logic                      out_valid;
   logic                      out_ready;
   instructions_pkg::arch_reg out_pc;
   instructions_pkg::arch_reg out_instr;

   modport master (
      input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
      output mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
      input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr
   );

endinterface
`default_nettype wire

// File: rtl/prefetch_slot_array.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : prefetch_slot_array                                                |
// | Brief  : Slot storage with allocate, fill and asynchronous read ports.      |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module prefetch_slot_array
   import fetch_pkg::*;
#(
   parameter int DEPTH = PREFETCH_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clear,
   input  logic                       i_alloc_en,
   input  logic [$clog2(DEPTH)-1:0]   i_alloc_idx,
   input  instructions_pkg::arch_reg  i_alloc_pc,
   input  logic                       i_fill_en,
   input  logic [$clog2(DEPTH)-1:0]   i_fill_idx,
   input  instructions_pkg::arch_reg  i_fill_instr,
   input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
   output prefetch_entry_t            o_rd_entry
);

   prefetch_entry_t r_slots [DEPTH];

   // Allocate and fill never target the same slot: a slot awaiting fill is never re-allocated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slots[i] <= '0;
         end
      end else if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slots[i].filled <= 1'b0;
         end
      end else begin
         if (i_alloc_en) begin
            r_slots[i_alloc_idx].pc     <= i_alloc_pc;
            r_slots[i_alloc_idx].filled <= 1'b0;
         end
         if (i_fill_en) begin
            r_slots[i_fill_idx].instr  <= i_fill_instr;
            r_slots[i_fill_idx].filled <= 1'b1;
         end
      end
   end

   assign o_rd_entry = r_slots[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : fetch_prefetch_buffer                                              |
// | Brief  : Sequential instruction prefetch queue with redirect flush.         |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module fetch_prefetch_buffer
   import instructions_pkg::*;
   import fetch_pkg::*;
#(
   parameter int      DEPTH    = PREFETCH_DEPTH,
   parameter arch_reg RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   fetch_prefetch_buffer_if.master bus
);

   localparam int                 c_IDX_W     = $clog2(DEPTH);
   localparam int                 c_PTR_W     = c_IDX_W + 1;
   localparam logic [c_PTR_W:0]   c_DEPTH_OCC = (c_PTR_W + 1)'(DEPTH);

   arch_reg                r_fetch_pc;
   logic [c_PTR_W-1:0]     r_head;
   logic [c_PTR_W-1:0]     r_alloc;
   logic [c_PTR_W-1:0]     r_fill;
   logic [c_PTR_W-1:0]     r_count;
   logic [c_PTR_W-1:0]     r_discard_cnt;

   logic [c_PTR_W-1:0]     w_unfilled;
   logic [c_PTR_W:0]       w_occupancy;
   logic                   w_req_fire;
   logic                   w_out_fire;
   logic                   w_resp_drop;
   logic                   w_resp_fill;
   prefetch_entry_t        w_head_entry;
   logic [1:0]             w_unused_pc_lsb;

   assign w_unused_pc_lsb = bus.redirect_pc[1:0];

   // Replies still owed to flushed requests occupy request credit until they drain.
   assign w_occupancy       = {1'b0, r_count} + {1'b0, r_discard_cnt};
   assign w_unfilled        = r_alloc - r_fill;
   assign bus.mem_req_valid = rst_n && !bus.redirect_valid && (w_occupancy < c_DEPTH_OCC);
   assign bus.mem_req_addr  = r_fetch_pc;
   assign w_req_fire        = bus.mem_req_valid && bus.mem_req_ready;
   assign w_resp_drop       = bus.mem_resp_valid && (r_discard_cnt != '0);
   assign w_resp_fill       = bus.mem_resp_valid && (r_discard_cnt == '0);

   assign bus.out_valid     = w_head_entry.filled && (r_count != '0);
   assign bus.out_pc        = w_head_entry.pc;
   assign bus.out_instr     = w_head_entry.instr;
   assign w_out_fire        = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_head        <= '0;
         r_alloc       <= '0;
         r_fill        <= '0;
         r_count       <= '0;
         r_discard_cnt <= '0;
      end else if (bus.redirect_valid) begin
         r_fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
         r_head        <= '0;
         r_alloc       <= '0;
         r_fill        <= '0;
         r_count       <= '0;
         r_discard_cnt <= r_discard_cnt + w_unfilled - c_PTR_W'(bus.mem_resp_valid);
      end else begin
         if (w_req_fire) begin
            r_alloc    <= r_alloc + 1'b1;
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_resp_drop) begin
            r_discard_cnt <= r_discard_cnt - 1'b1;
         end
         if (w_resp_fill) begin
            r_fill <= r_fill + 1'b1;
         end
         if (w_out_fire) begin
            r_head <= r_head + 1'b1;
         end
         r_count <= r_count + c_PTR_W'(w_req_fire) - c_PTR_W'(w_out_fire);
      end
   end

   prefetch_slot_array #(
      .DEPTH (DEPTH)
   ) u_slots (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (bus.redirect_valid),
      .i_alloc_en   (w_req_fire),
      .i_alloc_idx  (r_alloc[c_IDX_W-1:0]),
      .i_alloc_pc   (r_fetch_pc),
      .i_fill_en    (w_resp_fill),
      .i_fill_idx   (r_fill[c_IDX_W-1:0]),
      .i_fill_instr (bus.mem_resp_data),
      .i_rd_idx     (r_head[c_IDX_W-1:0]),
      .o_rd_entry   (w_head_entry)
   );

   // A reply with nothing outstanding means the memory lost request ordering.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!bus.mem_resp_valid || (r_discard_cnt != '0) || (w_unfilled != '0));
         assert (r_count == (r_alloc - r_head));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_fetch_prefetch_buffer                                           |
// | Brief  : Randomised bench with an epoch-tagged fetch/memory reference model.|
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_fetch_prefetch_buffer;
   import instructions_pkg::*;

   localparam int      c_DEPTH    = 4;
   localparam arch_reg c_RESET_PC = 32'h0000_0000;

   typedef struct {
      arch_reg addr;
      int      epoch;
   } pend_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fetch_prefetch_buffer_if bus();

   fetch_prefetch_buffer #(
      .DEPTH    (c_DEPTH),
      .RESET_PC (c_RESET_PC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int      n_checks  = 0;
   int      n_pass    = 0;
   int      dut_fires = 0;
   int      ret_cnt   = 0;
   int      epoch     = 0;
   arch_reg model_pc  = c_RESET_PC;
   pend_t   pend[$];
   arch_reg cur_q[$];

   task automatic check_eq(input string tag, input arch_reg act, input arch_reg exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
   endtask

   function automatic arch_reg mem_word(input arch_reg a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic int stale_count();
      int n = 0;
      foreach (pend[i]) if (pend[i].epoch != epoch) n++;
      return n;
   endfunction

   task automatic drive_idle();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      bus.out_ready      = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_pc", bus.out_pc, 32'd0);
      check_eq("rst_out_instr", bus.out_instr, 32'd0);
      check_eq("rst_req_addr", bus.mem_req_addr, c_RESET_PC);
   endtask

   // Reset asserts between edges; memory is reset alongside, so no replies survive.
   task automatic apply_reset(input int cycles);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      drive_idle();
      #1;
      check_reset_outputs();
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         check_reset_outputs();
      end
      @(negedge clk);
      rst_n = 1'b1;
      pend.delete();
      cur_q.delete();
      ret_cnt  = 0;
      epoch    = 0;
      model_pc = c_RESET_PC;
   endtask

   task automatic step(input bit redir, input arch_reg rpc, input bit ready, input bit resp_en,
                       input bit pop);
      bit    resp;
      bit    exp_req_valid;
      bit    exp_out_valid;
      pend_t p;
      @(negedge clk);
      resp = resp_en && (pend.size() > 0);
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.mem_req_ready  = ready;
      bus.mem_resp_valid = resp;
      bus.mem_resp_data  = resp ? mem_word(pend[0].addr) : arch_reg'($urandom);
      bus.out_ready      = pop;
      #1;
      exp_req_valid = !redir && ((cur_q.size() + stale_count()) < c_DEPTH);
      exp_out_valid = (cur_q.size() > 0) && (ret_cnt > 0);
      check_eq("req_valid", 32'(bus.mem_req_valid), 32'(exp_req_valid));
      check_eq("out_valid", 32'(bus.out_valid), 32'(exp_out_valid));
      if (exp_req_valid) check_eq("req_addr", bus.mem_req_addr, model_pc);
      if (exp_out_valid) begin
         check_eq("out_pc", bus.out_pc, cur_q[0]);
         check_eq("out_instr", bus.out_instr, mem_word(cur_q[0]));
      end
      if (bus.mem_req_valid && ready) dut_fires++;

      p = '{addr: '0, epoch: -1};
      if (resp) p = pend.pop_front();
      if (redir) begin
         epoch++;
         cur_q.delete();
         ret_cnt  = 0;
         model_pc = {rpc[31:2], 2'b00};
      end else begin
         if (resp && (p.epoch == epoch)) ret_cnt++;
         if (exp_out_valid && pop) begin
            void'(cur_q.pop_front());
            ret_cnt--;
         end
         if (exp_req_valid && ready) begin
            pend.push_back('{addr: model_pc, epoch: epoch});
            cur_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
         end
      end
   endtask

   initial begin
      bit      redir;
      arch_reg rpc;
      drive_idle();

      // Free-running stream: every request answered next cycle, consumer always ready.
      apply_reset(2);
      for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Stalled consumer: credit runs out after DEPTH requests.
      apply_reset(1);
      dut_fires = 0;
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check_eq("full_req_count", dut_fires, c_DEPTH);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Three unanswered requests flushed by a redirect.
      apply_reset(1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Redirect coinciding with a reply and an output pop.
      apply_reset(1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Unaligned redirect target and address wrap at the top of memory.
      step(1'b1, 32'h0000_0203, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Random traffic with redirects and occasional mid-burst resets.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            apply_reset(int'($urandom_range(1, 3)));
         end else begin
            redir = ($urandom_range(0, 19) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | arch_reg'($urandom_range(0, 15)))
                                                : arch_reg'($urandom);
            step(redir, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
